// File: rtl/dmem_stream_loader_if.sv
// Stream + memory bus bundle for dmem_stream_loader.
// master: the loader (consumes the byte stream, drives the memory write port).
// slave:  the environment (byte source and data memory).
interface dmem_stream_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8
);
  logic                     in_valid;
  logic [BYTE_WIDTH-1:0]    in_data;
  logic                     in_ready;
  logic                     mem_we;
  logic                     mem_byte_op;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    input  in_valid, in_data, mem_rdata,
    output in_ready, mem_we, mem_byte_op, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_rdata,
    input  in_ready, mem_we, mem_byte_op, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_stream_loader.sv
// dmem_stream_loader: packs a byte stream into big-endian words and writes them
// into the data memory starting at BASE_ADDR; a 1-3 byte tail is written with
// single-byte accesses.
// Optional feature macro: READBACK_CHECK_EN -- after every word write the word
// is read back for one cycle and a mismatch sets the sticky error flag.
// The interface instance must use the same widths as this module's parameters.
module dmem_stream_loader #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       BYTE_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'h10000,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_BYTES     = 32'h10000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] length,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  dmem_stream_loader_if.master     bus
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int LW    = $clog2(LANES + 1);

  if ((int'(BASE_ADDR) % LANES) != 0) begin : g_base_align_check
    $error("dmem_stream_loader: BASE_ADDR must be word aligned");
  end

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WR_WORD,
    WR_TAIL,
`ifdef READBACK_CHECK_EN
    VERIFY,
`endif
    DONE
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] remaining;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [LW-1:0]            lane;
  logic [LW-1:0]            tail_idx;
  logic [LW-1:0]            tail_cnt;
  logic [DATA_WIDTH-1:0]    pack;
  logic [DATA_WIDTH-1:0]    pack_merged;
  logic [BYTE_WIDTH-1:0]    tail_byte;
  logic [ADDRESS_WIDTH-1:0] length_clamped;

  assign length_clamped = (length > MAX_BYTES) ? MAX_BYTES : length;

`ifndef READBACK_CHECK_EN
  logic unused_rdata;
  assign unused_rdata = ^bus.mem_rdata;
`endif

  // Pack register with the incoming byte dropped into the current lane (lane 0 = MSB)
  always_comb begin
    pack_merged = pack;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LW'(i)) pack_merged[DATA_WIDTH-1-BYTE_WIDTH*i -: BYTE_WIDTH] = bus.in_data;
    end
  end

  // Selects the tail byte to be written next, in stream order
  always_comb begin
    tail_byte = '0;
    for (int i = 0; i < LANES; i++) begin
      if (tail_idx == LW'(i)) tail_byte = pack[DATA_WIDTH-1-BYTE_WIDTH*i -: BYTE_WIDTH];
    end
  end

  // Loader FSM; every output is registered and set on entry to the state that owns it
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      remaining       <= '0;
      addr            <= '0;
      lane            <= '0;
      tail_idx        <= '0;
      tail_cnt        <= '0;
      pack            <= '0;
      bus.in_ready    <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_byte_op <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            remaining <= length_clamped;
            addr      <= BASE_ADDR;
            lane      <= '0;
            error     <= 1'b0;
            if (length_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state        <= COLLECT;
              busy         <= 1'b1;
              bus.in_ready <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (bus.in_valid && bus.in_ready) begin
            pack      <= pack_merged;
            remaining <= remaining - ADDRESS_WIDTH'(1);
            lane      <= lane + LW'(1);
            if (lane + LW'(1) == LW'(LANES)) begin
              state           <= WR_WORD;
              bus.in_ready    <= 1'b0;
              bus.mem_we      <= 1'b1;
              bus.mem_byte_op <= 1'b0;
              bus.mem_addr    <= addr;
              bus.mem_wdata   <= pack_merged;
            end else if (remaining == ADDRESS_WIDTH'(1)) begin
              state           <= WR_TAIL;
              bus.in_ready    <= 1'b0;
              bus.mem_we      <= 1'b1;
              bus.mem_byte_op <= 1'b1;
              bus.mem_addr    <= addr;
              bus.mem_wdata   <= DATA_WIDTH'(pack_merged[DATA_WIDTH-1 -: BYTE_WIDTH]);
              addr            <= addr + ADDRESS_WIDTH'(1);
              tail_idx        <= LW'(1);
              tail_cnt        <= lane + LW'(1);
            end
          end
        end

        WR_WORD: begin
          lane       <= '0;
          bus.mem_we <= 1'b0;
`ifdef READBACK_CHECK_EN
          state           <= VERIFY;
          bus.mem_byte_op <= 1'b0;
`else
          addr <= addr + ADDRESS_WIDTH'(LANES);
          if (remaining == '0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state        <= COLLECT;
            bus.in_ready <= 1'b1;
          end
`endif
        end

`ifdef READBACK_CHECK_EN
        VERIFY: begin
          if (bus.mem_rdata != pack) error <= 1'b1;
          addr <= addr + ADDRESS_WIDTH'(LANES);
          if (remaining == '0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state        <= COLLECT;
            bus.in_ready <= 1'b1;
          end
        end
`endif

        WR_TAIL: begin
          if (tail_idx == tail_cnt) begin
            state           <= DONE;
            bus.mem_we      <= 1'b0;
            bus.mem_byte_op <= 1'b0;
            done            <= 1'b1;
            busy            <= 1'b0;
          end else begin
            bus.mem_addr  <= addr;
            bus.mem_wdata <= DATA_WIDTH'(tail_byte);
            addr          <= addr + ADDRESS_WIDTH'(1);
            tail_idx      <= tail_idx + LW'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          bus.mem_we   <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stream_loader.sv
// Self-checking bench for dmem_stream_loader: directed loads plus randomized
// lengths, byte values and in_valid patterns, checked against a write list
// computed directly from the stream and the length clamp.
module tb_dmem_stream_loader;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          BW   = 8;
  localparam logic [31:0] BASE = 32'h10000;
  localparam logic [31:0] MAXB = 32'd37;

  typedef struct packed {
    logic [31:0] addr;
    logic        byte_op;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] length;
  logic        busy;
  logic        done;
  logic        error;
  logic        corrupt_en;

  int checks   = 0;
  int failures = 0;
  int done_total  = 0;
  int ready_total = 0;

  logic [7:0] stim[$];
  wr_t        obs_q[$];
  wr_t        exp_q[$];
  logic [7:0] mem_b [0:255];
  logic [7:0] rd_off;
  logic [31:0] rd_word;

  dmem_stream_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();

  dmem_stream_loader #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW),
    .BASE_ADDR(BASE), .MAX_BYTES(MAXB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .busy(busy), .done(done), .error(error), .bus(bus)
  );

  always #5 clk = ~clk;

  // Byte-addressed memory model, big-endian words
  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_byte_op) mem_b[8'(bus.mem_addr - BASE)] <= bus.mem_wdata[7:0];
      else for (int k = 0; k < 4; k++) mem_b[8'(bus.mem_addr - BASE + 32'(k))] <= bus.mem_wdata[31-8*k -: 8];
    end
  end

  // Combinational read port, optionally corrupting the word at BASE+4
  always_comb begin
    rd_off  = 8'(bus.mem_addr - BASE);
    rd_word = {mem_b[rd_off], mem_b[rd_off + 8'd1], mem_b[rd_off + 8'd2], mem_b[rd_off + 8'd3]};
    if (corrupt_en && bus.mem_addr == BASE + 32'd4) rd_word = rd_word ^ 32'h1;
    bus.mem_rdata = rd_word;
  end

  // Write/handshake monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.mem_we) obs_q.push_back('{bus.mem_addr, bus.mem_byte_op, bus.mem_wdata});
    if (done) done_total++;
    if (bus.in_ready) ready_total++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: clamp the length, whole words first, then the tail as single bytes
  function automatic void build_expected(input logic [31:0] len);
    int n, words, tail;
    n = (len > MAXB) ? int'(MAXB) : int'(len);
    words = n / 4;
    tail  = n % 4;
    exp_q.delete();
    for (int w = 0; w < words; w++)
      exp_q.push_back('{BASE + 32'(4*w), 1'b0, {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]}});
    for (int t = 0; t < tail; t++)
      exp_q.push_back('{BASE + 32'(4*words + t), 1'b1, {24'h0, stim[4*words + t]}});
  endfunction

  function automatic void fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endfunction

  // mode 0: in_valid always high, 1: toggling, 2: random, 3: toggling plus a stray start
  task automatic applyStimulus(input logic [31:0] len, input int mode, input string name,
                               input logic exp_err, output int lat, output int rdy);
    int n, idx, cyc, obs_base, done_base, ready_base;
    bit got_done, extra_ready;
    logic v;
    n = (len > MAXB) ? int'(MAXB) : int'(len);
    build_expected(len);
    @(negedge clk);
    obs_base   = obs_q.size();
    done_base  = done_total;
    ready_base = ready_total;
    start  = 1'b1;
    length = len;
    @(negedge clk);
    start  = 1'b0;
    length = 32'($urandom);
    checkOutput({name, "_err_clear"}, 64'(error), 64'(0));
    if (n > 0) checkOutput({name, "_busy"}, 64'(busy), 64'(1));
    idx = 0; cyc = 0; got_done = 0; extra_ready = 0;
    while (!got_done && cyc < 600) begin
      if (done) got_done = 1;
      else begin
        start = (mode == 3 && cyc == 5);
        if (start) length = 32'd3;
        if (idx < n) begin
          case (mode)
            0:       v = 1'b1;
            1, 3:    v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
          endcase
          bus.in_valid = v;
          bus.in_data  = stim[idx];
          if (v && bus.in_ready) idx++;
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = 8'h5A;
          if (bus.in_ready) extra_ready = 1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    lat = cyc;
    checkOutput({name, "_done_seen"}, 64'(got_done), 64'(1));
    checkOutput({name, "_busy_at_done"}, 64'(busy), 64'(0));
    checkOutput({name, "_error"}, 64'(error), 64'(exp_err));
    checkOutput({name, "_extra_ready"}, 64'(extra_ready), 64'(0));
    @(negedge clk);
    checkOutput({name, "_done_pulse"}, 64'(done), 64'(0));
    checkOutput({name, "_done_count"}, 64'(done_total - done_base), 64'(1));
    checkOutput({name, "_error_hold"}, 64'(error), 64'(exp_err));
    rdy = ready_total - ready_base;
    checkOutput({name, "_wr_count"}, 64'(obs_q.size() - obs_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++) begin
      checkOutput({name, "_addr"},    64'(obs_q[obs_base+i].addr),    64'(exp_q[i].addr));
      checkOutput({name, "_byte_op"}, 64'(obs_q[obs_base+i].byte_op), 64'(exp_q[i].byte_op));
      checkOutput({name, "_wdata"},   64'(obs_q[obs_base+i].data),    64'(exp_q[i].data));
    end
  endtask

  task automatic check_reset_values(input string name);
    checkOutput({name, "_in_ready"}, 64'(bus.in_ready), 64'(0));
    checkOutput({name, "_mem_we"},   64'(bus.mem_we), 64'(0));
    checkOutput({name, "_byte_op"},  64'(bus.mem_byte_op), 64'(0));
    checkOutput({name, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
    checkOutput({name, "_wdata"},    64'(bus.mem_wdata), 64'(0));
    checkOutput({name, "_busy"},     64'(busy), 64'(0));
    checkOutput({name, "_done"},     64'(done), 64'(0));
    checkOutput({name, "_error"},    64'(error), 64'(0));
  endtask

  initial begin
    int lat, rdy, idx, cyc, obs_base;
    logic [31:0] len;
    rst = 1'b1; start = 1'b0; length = '0; corrupt_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    $display("[TB] directed: 8-byte load");
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    applyStimulus(32'd8, 0, "t1", 1'b0, lat, rdy);

    $display("[TB] directed: 6-byte load with tail");
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    applyStimulus(32'd6, 0, "t2", 1'b0, lat, rdy);

    $display("[TB] directed: zero length");
    stim.delete();
    applyStimulus(32'd0, 0, "t3", 1'b0, lat, rdy);
    checkOutput("t3_latency", 64'(lat), 64'(0));
    checkOutput("t3_ready_never", 64'(rdy), 64'(0));

    $display("[TB] directed: toggling valid with stray start");
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    applyStimulus(32'd8, 3, "t4", 1'b0, lat, rdy);

    $display("[TB] directed: reset mid-load");
    fill_random(8);
    @(negedge clk);
    start = 1'b1; length = 32'd8;
    @(negedge clk);
    start = 1'b0;
    obs_base = obs_q.size();
    idx = 0; cyc = 0;
    while (idx < 3 && cyc < 50) begin
      bus.in_valid = 1'b1;
      bus.in_data  = stim[idx];
      if (bus.in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("t5_bytes_fed", 64'(idx), 64'(3));
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("t5");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("t5_no_write", 64'(obs_q.size() - obs_base), 64'(0));
    checkOutput("t5_idle_busy", 64'(busy), 64'(0));
    checkOutput("t5_idle_ready", 64'(bus.in_ready), 64'(0));

`ifdef READBACK_CHECK_EN
    $display("[TB] directed: readback corruption");
    corrupt_en = 1'b1;
    fill_random(8);
    applyStimulus(32'd8, 0, "t6", 1'b1, lat, rdy);
    corrupt_en = 1'b0;
    fill_random(4);
    applyStimulus(32'd4, 0, "t6_clear", 1'b0, lat, rdy);
`endif

    $display("[TB] randomized loads");
    for (int it = 0; it < 12; it++) begin
      len = (it == 3) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 45));
      fill_random((len > MAXB) ? int'(MAXB) : int'(len));
      applyStimulus(len, $urandom_range(0, 2), "rnd", 1'b0, lat, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
